// File: rtl/seg_scanner_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
//   Shared constants for the 8-digit, common-anode 7-segment scanner.
//   All segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
//   Contents:
//     NUM_DIGITS : number of scanned digits (8)
//     SEG_OFF    : all segments dark
//     AN_OFF     : all digit enables inactive
//     HEX_SEG    : 16-entry hex glyph table, entry n is the pattern for nibble n
// ----------------------------------------------------------------------------
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Packed so that HEX_SEG[n] selects the glyph for nibble n (entry 0 is the
  // rightmost element of the concatenation).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg_scanner_if.sv
// ----------------------------------------------------------------------------
// seg_scanner_if
//   Bundle between the I/O unit / display pins and the scanner.
//   Signals:
//     d          [31:0] value to display, nibble i on digit i
//     an         [7:0]  digit enables, active-low
//     cn         [6:0]  segment drives, active-low {g,f,e,d,c,b,a}
//     frame_sync        one-cycle pulse when a new snapshot of d is taken
//   Modports:
//     master : the scanner (consumes d, drives the display outputs)
//     slave  : the surroundings (supplies d, observes the display outputs)
// ----------------------------------------------------------------------------
interface seg_scanner_if;

  logic [31:0] d;
  logic [7:0]  an;
  logic [6:0]  cn;
  logic        frame_sync;

  modport master (
    input  d,
    output an,
    output cn,
    output frame_sync
  );

  modport slave (
    output d,
    input  an,
    input  cn,
    input  frame_sync
  );

endinterface

// File: rtl/seg_scanner_hex7seg.sv
// ----------------------------------------------------------------------------
// hex7seg
//   Purely combinational hex-to-7-segment decoder (active-low outputs).
//   Ports:
//     nib_i [3:0] : nibble to show
//     seg_o [6:0] : segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
// ----------------------------------------------------------------------------
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_scanner.sv
// ----------------------------------------------------------------------------
// seg_scanner
//   Time-multiplexed driver for an 8-digit common-anode 7-segment display.
//   Each digit gets a slot of DIV clk_glb cycles; eight slots form a frame.
//   The display value is snapshotted once per frame (at the end of digit 7's
//   slot) so a frame never mixes nibbles of two different values.
//   All display outputs are registered.
//
//   Parameters:
//     DIV       : cycles per digit slot, 2..2^20
//     BLANK_CYC : dark cycles at the start of every slot, < DIV
//   Ports:
//     clk_glb : system clock, rising edge
//     rstn    : asynchronous active-low reset
//     disp_if : seg_scanner_if.master (d in; an, cn, frame_sync out)
//   Build option:
//     SEG_SCANNER_LZB_EN : when defined, leading-zero digits (1..7) are
//                          kept dark; digit 0 is always lit.
// ----------------------------------------------------------------------------
module seg_scanner
  import seg_pkg::*;
#(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 0
) (
  input  logic          clk_glb,
  input  logic          rstn,
  seg_scanner_if.master disp_if
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      frame_q, frame_d;
  logic             fs_q, fs_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       cn_q, cn_d;

  logic             tick;
  logic             slot_blank;
  logic             lz_dark;
  logic [6:0]       seg_w;
  logic [3:0]       nib [NUM_DIGITS];

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = frame_q[4*gi +: 4];
  end

  hex7seg u_hex7seg (
    .nib_i (nib[idx_q]),
    .seg_o (seg_w)
  );

  // With no blanking configured the compare would be constant, so it is
  // only elaborated when there is something to blank.
  if (BLANK_CYC > 0) begin : g_blank
    assign slot_blank = (cnt_q < CNT_W'(BLANK_CYC));
  end else begin : g_noblank
    assign slot_blank = 1'b0;
  end

`ifdef SEG_SCANNER_LZB_EN
  // upper_zero[i]: every nibble from digit i upward is zero.
  logic [NUM_DIGITS-1:0] upper_zero;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign upper_zero[gi] = ~|frame_q[31:4*gi];
  end
  assign lz_dark = (idx_q != 3'd0) && upper_zero[idx_q];
`else
  assign lz_dark = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    fs_d    = 1'b0;
    an_d    = AN_OFF;
    cn_d    = SEG_OFF;

    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;        // 7 wraps to 0 naturally
      if (idx_q == 3'd7) begin
        frame_d = disp_if.d;       // new frame starts with a fresh snapshot
        fs_d    = 1'b1;
      end
    end

    // Outputs reflect the pre-edge idx/cnt/frame, hence one cycle of latency.
    if (!(slot_blank || lz_dark)) begin
      an_d = ~(8'b1 << idx_q);
      cn_d = seg_w;
    end
  end

  always_ff @(posedge clk_glb or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      fs_q    <= 1'b0;
      an_q    <= AN_OFF;
      cn_q    <= SEG_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      fs_q    <= fs_d;
      an_q    <= an_d;
      cn_q    <= cn_d;
    end
  end

  assign disp_if.an         = an_q;
  assign disp_if.cn         = cn_q;
  assign disp_if.frame_sync = fs_q;

endmodule

// File: tb/tb_seg_scanner.sv
// ----------------------------------------------------------------------------
// tb_seg_scanner
//   Two scanners with DIV=4 share clock, reset and d: dut0 with BLANK_CYC=0,
//   dut1 with BLANK_CYC=1. The stimulus process pushes the expected outputs
//   of both after every rising edge; the monitor pops and compares on the
//   falling edge. Frame contents are listed in FV, one entry per frame.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg_scanner;

  typedef struct packed {
    logic [7:0] an0;
    logic [6:0] cn0;
    logic [7:0] an1;
    logic [6:0] cn1;
    logic       fs;
  } exp_t;

`ifdef SEG_SCANNER_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Active-low glyphs for nibbles 0..F.
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Frame contents in order: frames 0..6 of the first run (frame 0 is the
  // post-reset zero frame), frames 7..8 after the mid-frame reset.
  localparam logic [31:0] FV [9] = '{
    32'h0000_0000, 32'h89AB_CDEF, 32'h1111_1111, 32'h2222_2222,
    32'h0000_00A5, 32'h0000_0000, 32'h1234_5678,
    32'h0000_0000, 32'h1234_5678
  };

  localparam exp_t RST_EXP = '{an0: 8'hFF, cn0: 7'h7F, an1: 8'hFF, cn1: 7'h7F, fs: 1'b0};

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] d_tb;

  int   checks = 0;
  int   errors = 0;
  int   mon_cyc = 0;
  exp_t q[$];

  seg_scanner_if disp0 ();
  seg_scanner_if disp1 ();

  assign disp0.d = d_tb;
  assign disp1.d = d_tb;

  seg_scanner #(.DIV(4), .BLANK_CYC(0)) u_dut0 (
    .clk_glb (clk),
    .rstn    (rstn),
    .disp_if (disp0)
  );

  seg_scanner #(.DIV(4), .BLANK_CYC(1)) u_dut1 (
    .clk_glb (clk),
    .rstn    (rstn),
    .disp_if (disp1)
  );

  always #5 clk = ~clk;

  // Expected outputs after rising edge k (k=1 is the first edge after reset
  // release); base selects the first frame of this run in FV.
  function automatic exp_t expect_at(int k, int base);
    exp_t        e;
    int          f;
    int          dig;
    int          sub;
    logic [31:0] v;
    logic [31:0] upper;
    logic [3:0]  n;
    bit          dark;
    f     = base + (k - 1) / 32;
    dig   = ((k - 1) / 4) % 8;
    sub   = (k - 1) % 4;
    v     = FV[f];
    upper = v >> (4 * dig);
    n     = upper[3:0];
    dark  = LZB && (dig > 0) && (upper == 32'd0);
    e.fs  = (k % 32 == 0);
    if (dark) begin
      e.an0 = 8'hFF; e.cn0 = 7'h7F;
    end else begin
      e.an0 = ~(8'd1 << dig); e.cn0 = SEG[n];
    end
    if (dark || sub == 0) begin
      e.an1 = 8'hFF; e.cn1 = 7'h7F;
    end else begin
      e.an1 = e.an0; e.cn1 = e.cn0;
    end
    return e;
  endfunction

  task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: one transaction per falling edge while expectations are queued.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      mon_cyc++;
      $display("cyc %0d dut0 an=%h cn=%h | dut1 an=%h cn=%h | fs=%b%b",
               mon_cyc, disp0.an, disp0.cn, disp1.an, disp1.cn,
               disp0.frame_sync, disp1.frame_sync);
      chk("an0",  mon_cyc, 32'(disp0.an),         32'(e.an0));
      chk("cn0",  mon_cyc, 32'(disp0.cn),         32'(e.cn0));
      chk("fs0",  mon_cyc, 32'(disp0.frame_sync), 32'(e.fs));
      chk("an1",  mon_cyc, 32'(disp1.an),         32'(e.an1));
      chk("cn1",  mon_cyc, 32'(disp1.cn),         32'(e.cn1));
      chk("fs1",  mon_cyc, 32'(disp1.frame_sync), 32'(e.fs));
    end
  end

  // Runs n_edges rising edges from a fresh reset release. If rst_at > 0,
  // reset is asserted asynchronously 1 ns after that edge.
  task automatic run(int base, int n_edges, int rst_at);
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk);
      if (k == rst_at) begin
        q.push_back(RST_EXP);
        #1 rstn = 1'b0;
      end else begin
        q.push_back(expect_at(k, base));
        #1;
        if (base == 0) begin
          case (k)
            32:  d_tb = 32'h1111_1111;
            77:  d_tb = 32'h2222_2222;   // idx==3 inside a frame of 1s
            96:  d_tb = 32'h0000_00A5;
            128: d_tb = 32'h0000_0000;
            160: d_tb = 32'h1234_5678;
            default: ;
          endcase
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    d_tb = 32'h89AB_CDEF;
    repeat (3) begin
      @(posedge clk);
      q.push_back(RST_EXP);
    end
    @(negedge clk);
    #1 rstn = 1'b1;

    // Frame 6 digit 5 is shown on edges 213..216; reset lands mid-slot.
    run(0, 214, 214);

    repeat (2) begin
      @(posedge clk);
      q.push_back(RST_EXP);
    end
    @(negedge clk);
    #1 rstn = 1'b1;

    run(7, 36, 0);

    @(negedge clk);
    #1;
    chk("drain", mon_cyc, 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
